// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: in-flight destination scoreboard, per-operand bypass selects, load stall.
// Optional stall-cycle counter is built only when FWD_PERF_CNT_EN is defined.
module fwd_hazard_unit #(
  parameter int REG_W    = 5,
  parameter int DEPTH    = 3,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 2,
  localparam int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic                    issue_wr,
  input  logic [REG_W-1:0]        issue_rd,
  input  logic                    issue_is_load,
  input  logic                    flush,
  input  logic [NSRC*REG_W-1:0]   id_src,
  input  logic [NSRC-1:0]         id_src_used,
  output logic                    stall,
  output logic [NSRC*SEL_W-1:0]   fwd_sel_ex,
  output logic [31:0]             stall_cnt
);

  // The oldest (WB) stage is covered by register-file write-through, so only
  // the forwardable stages 0..DEPTH-2 are held.
  localparam int NE = DEPTH - 1;

  logic [NE-1:0]     v_r;
  logic [NE-1:0]     ld_r;
  logic [REG_W-1:0]  rd_r [NE];
  logic [NSRC*SEL_W-1:0] sel_s;
  logic [NSRC-1:0]   haz_s;
  logic              stall_s;
  logic              new_v_s;
  logic [NSRC*SEL_W-1:0] fwd_sel_ex_r;

  assign new_v_s = issue_valid & issue_wr & (issue_rd != {REG_W{1'b0}}) & ~stall_s & ~flush;

  // Scoreboard shift: new entry (or bubble) enters stage 0 every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_r  <= {NE{1'b0}};
      ld_r <= {NE{1'b0}};
      for (int i = 0; i < NE; i++) begin
        rd_r[i] <= {REG_W{1'b0}};
      end
    end else begin
      v_r[0]  <= new_v_s;
      ld_r[0] <= issue_is_load;
      rd_r[0] <= issue_rd;
      for (int i = 1; i < NE; i++) begin
        v_r[i]  <= v_r[i-1];
        ld_r[i] <= ld_r[i-1];
        rd_r[i] <= rd_r[i-1];
      end
    end
  end

  // Select lookup: scan oldest to youngest so the youngest match is written last.
  always_comb begin
    sel_s = {NSRC*SEL_W{1'b0}};
    haz_s = {NSRC{1'b0}};
    for (int j = 0; j < NSRC; j++) begin
      for (int i = NE - 1; i >= 0; i--) begin
        sel_s[j*SEL_W +: SEL_W] =
          (id_src_used[j] && (id_src[j*REG_W +: REG_W] != {REG_W{1'b0}}) &&
           v_r[i] && (rd_r[i] == id_src[j*REG_W +: REG_W]))
          ? SEL_W'(i + 1) : sel_s[j*SEL_W +: SEL_W];
        haz_s[j] =
          (id_src_used[j] && (id_src[j*REG_W +: REG_W] != {REG_W{1'b0}}) &&
           v_r[i] && (rd_r[i] == id_src[j*REG_W +: REG_W]))
          ? (ld_r[i] && ((i + 1) < LOAD_LAT)) : haz_s[j];
      end
    end
  end

  assign stall_s = issue_valid & ~flush & (|haz_s);
  assign stall   = stall_s;

  // EX-stage select register; stalled, flushed or empty issue slots become bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_sel_ex_r <= {NSRC*SEL_W{1'b0}};
    end else if (stall_s || flush || !issue_valid) begin
      fwd_sel_ex_r <= {NSRC*SEL_W{1'b0}};
    end else begin
      fwd_sel_ex_r <= sel_s;
    end
  end

  assign fwd_sel_ex = fwd_sel_ex_r;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] cnt_r;

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 32'd0;
    end else if (stall_s && (cnt_r != 32'hFFFF_FFFF)) begin
      cnt_r <= cnt_r + 32'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign stall_cnt = cnt_r;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit with default parameters.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic        issue_wr;
  logic [4:0]  issue_rd;
  logic        issue_is_load;
  logic        flush;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        stall;
  logic [3:0]  fwd_sel_ex;
  logic [31:0] stall_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  fwd_hazard_unit dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_wr     (issue_wr),
    .issue_rd     (issue_rd),
    .issue_is_load(issue_is_load),
    .flush        (flush),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .stall        (stall),
    .fwd_sel_ex   (fwd_sel_ex),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wr, input logic [4:0] rd, input logic ld,
                       input logic fl, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used);
    issue_valid   = v;
    issue_wr      = wr;
    issue_rd      = rd;
    issue_is_load = ld;
    flush         = fl;
    id_src        = {s1, s0};
    id_src_used   = used;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_cnt;

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    tick();
    chk("reset_fwd", {28'd0, fwd_sel_ex}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_cnt", stall_cnt, 32'd0);
    reset = 1'b0;

    // ALU back-to-back, then distance 2, then beyond the forwarding window
    drive(1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, 2'b01);
    chk("alu_d1_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("alu_d1_sel", {28'd0, fwd_sel_ex}, 32'h1);
    tick();
    chk("alu_d2_sel", {28'd0, fwd_sel_ex}, 32'h2);
    tick();
    chk("alu_wb_sel", {28'd0, fwd_sel_ex}, 32'h0);

    // Load-use: one stall cycle, bubble into EX, then distance-2 forward
    drive(1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd5, 2'b10);
    chk("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_bubble", {28'd0, fwd_sel_ex}, 32'h0);
    chk("lu_stall_clear", {31'd0, stall}, 32'd0);
    tick();
    chk("lu_sel", {28'd0, fwd_sel_ex}, 32'h8);
`ifdef FWD_PERF_CNT_EN
    exp_cnt = 32'd1;
`else
    exp_cnt = 32'd0;
`endif
    chk("lu_cnt", stall_cnt, exp_cnt);

    // Priority: younger sub r4 wins over older add r4 on both operands
    drive(1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 5'd4, 2'b11);
    chk("prio_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("prio_sel", {28'd0, fwd_sel_ex}, 32'h5);

    // Younger add r7 shadows older lw r7
    drive(1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd0, 2'b01);
    chk("shadow_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("shadow_sel", {28'd0, fwd_sel_ex}, 32'h1);

    // Register zero never matches
    drive(1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b11);
    chk("zero_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("zero_sel", {28'd0, fwd_sel_ex}, 32'h0);

    // Unused operand with matching number
    drive(1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd6, 5'd6, 2'b00);
    chk("unused_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("unused_sel", {28'd0, fwd_sel_ex}, 32'h0);

    // Flush beats load-use stall and never writes stage 0
    drive(1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 5'd5, 5'd0, 2'b01);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("flush_sel", {28'd0, fwd_sel_ex}, 32'h0);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd9, 2'b11);
    chk("flush_nowrite_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("flush_nowrite_sel", {28'd0, fwd_sel_ex}, 32'h0);
    chk("cnt_hold", stall_cnt, exp_cnt);

    // Reset mid-stream with a scoreboard full of r2 writers
    drive(1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    tick();
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd2, 5'd2, 2'b11);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_cnt", stall_cnt, 32'd0);
    tick();
    chk("rst_mid_sel", {28'd0, fwd_sel_ex}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
